ram_nport: RTL and testbench

- Generalised multi-port synchronous RAM with NUM_PORTS read/write ports on one clock.
- Adds per-byte write enables, selectable read latency and read-during-write mode, deterministic write-collision arbitration, and a post-reset memory-clear sequencer.
- Used as the shared scratch/data memory between CPU, DMA and peripheral blocks in the FPGA designs.

---
 rtl/ram_nport_if.sv | 28 ++
 rtl/ram_nport.sv | 162 ++++++++++++++++
 tb/tb_ram_nport.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_nport_if.sv
// Request/response bundle for ram_nport. Each per-port field is packed with
// port p in slice p.
interface ram_nport_if #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_BITS = 3,
    parameter int WORD_BITS = 8,
    parameter int NUM_BYTES = 1
);
    logic [NUM_PORTS-1:0]           in_read_ena;
    logic [NUM_PORTS-1:0]           in_write_ena;
    logic [NUM_PORTS*NUM_BYTES-1:0] in_byte_ena;
    logic [NUM_PORTS*ADDR_BITS-1:0] in_addr;
    logic [NUM_PORTS*WORD_BITS-1:0] in_data;
    logic [NUM_PORTS*WORD_BITS-1:0] out_data;
    logic [NUM_PORTS-1:0]           out_valid;
    logic [NUM_PORTS-1:0]           out_collision;
    logic                           out_busy;

    modport master (
        output in_read_ena, in_write_ena, in_byte_ena, in_addr, in_data,
        input  out_data, out_valid, out_collision, out_busy
    );

    modport slave (
        input  in_read_ena, in_write_ena, in_byte_ena, in_addr, in_data,
        output out_data, out_valid, out_collision, out_busy
    );
endinterface

// File: rtl/ram_nport.sv
// Multi-port synchronous RAM: byte-lane writes, lowest-index-wins write
// arbitration with collision flags, 1 or 2 cycle read latency, selectable
// read-during-write behaviour and a post-reset clear sequencer.
module ram_nport #(
    parameter int ADDR_BITS      = 3,
    parameter int WORD_BITS      = 8,
    parameter int NUM_WORDS      = 2**ADDR_BITS,
    parameter int NUM_PORTS      = 2,
    parameter int BYTE_BITS      = 8,
    parameter int READ_LATENCY   = 1,
    parameter int WRITE_MODE     = 0,
    parameter int ALL_WRITE      = 1,
    parameter int CLEAR_ON_RESET = 1,
    parameter logic [WORD_BITS-1:0] INIT_VALUE = '0
) (
    input logic        in_clk,
    input logic        in_rst,
    ram_nport_if.slave bus
);
    localparam int NUM_BYTES = WORD_BITS / BYTE_BITS;
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(NUM_WORDS - 1);
    localparam logic [31:0] WORDS_32 = 32'(NUM_WORDS);

    typedef enum logic {CLEAR, READY} state_t;

    state_t                 state;
    logic [ADDR_BITS-1:0]   clr_cnt;
    logic                   busy;
    logic                   ready;

    logic [WORD_BITS-1:0]   mem [NUM_WORDS];

    logic [ADDR_BITS-1:0]   addr  [NUM_PORTS];
    logic [WORD_BITS-1:0]   wdata [NUM_PORTS];
    logic [NUM_BYTES-1:0]   be    [NUM_PORTS];
    logic [WORD_BITS-1:0]   rd_word [NUM_PORTS];
    logic [NUM_PORTS-1:0]   in_range;
    logic [NUM_PORTS-1:0]   rd_req;
    logic [NUM_PORTS-1:0]   wr_req;
    logic [NUM_PORTS-1:0]   wr_win;
    logic [NUM_PORTS-1:0]   wr_lose;

    logic [NUM_PORTS*WORD_BITS-1:0] s1_data, s2_data;
    logic [NUM_PORTS-1:0]           s1_valid, s2_valid;
    logic [NUM_PORTS-1:0]           collision;

    assign ready = (state == READY);

    // Unpack per-port fields and qualify read/write requests.
    always_comb begin
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            addr[p]     = bus.in_addr[p*ADDR_BITS +: ADDR_BITS];
            wdata[p]    = bus.in_data[p*WORD_BITS +: WORD_BITS];
            be[p]       = bus.in_byte_ena[p*NUM_BYTES +: NUM_BYTES];
            in_range[p] = ({{(32-ADDR_BITS){1'b0}}, addr[p]} < WORDS_32);
            rd_req[p]   = ready && bus.in_read_ena[p];
            wr_req[p]   = ready && ((ALL_WRITE != 0) || (p == 0)) &&
                          bus.in_write_ena[p] && in_range[p] && (|be[p]);
        end
    end

    // Lowest-index writer to an address takes the whole word; others lose.
    always_comb begin
        wr_win = wr_req;
        for (int unsigned p = 1; p < NUM_PORTS; p++) begin
            for (int unsigned q = 0; q < p; q++) begin
                if (wr_req[q] && (addr[q] == addr[p])) begin
                    wr_win[p] = 1'b0;
                end
            end
        end
        wr_lose = wr_req & ~wr_win;
    end

    // Read word per port; write-first overlays the winning writer's lanes.
    always_comb begin
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            rd_word[p] = '0;
            if (rd_req[p] && in_range[p]) begin
                rd_word[p] = mem[addr[p]];
                if (WRITE_MODE != 0) begin
                    for (int unsigned q = 0; q < NUM_PORTS; q++) begin
                        if (wr_win[q] && (addr[q] == addr[p])) begin
                            for (int unsigned b = 0; b < NUM_BYTES; b++) begin
                                if (be[q][b]) begin
                                    rd_word[p][b*BYTE_BITS +: BYTE_BITS] =
                                        wdata[q][b*BYTE_BITS +: BYTE_BITS];
                                end
                            end
                        end
                    end
                end
            end
        end
    end

    // Clear/ready sequencer with registered busy flag.
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            state   <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
            clr_cnt <= '0;
            busy    <= (CLEAR_ON_RESET != 0);
        end else begin
            case (state)
                CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == LAST_ADDR) begin
                        state   <= READY;
                        busy    <= 1'b0;
                        clr_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Storage array: clear writes while clearing, else arbitrated lane writes.
    // Gated by reset so nothing lands in memory while reset is held.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            if (state == CLEAR) begin
                mem[clr_cnt] <= INIT_VALUE;
            end else begin
                for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                    if (wr_win[p]) begin
                        for (int unsigned b = 0; b < NUM_BYTES; b++) begin
                            if (be[p][b]) begin
                                mem[addr[p]][b*BYTE_BITS +: BYTE_BITS] <=
                                    wdata[p][b*BYTE_BITS +: BYTE_BITS];
                            end
                        end
                    end
                end
            end
        end
    end

    // Read output pipeline and registered collision flags.
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            s1_data   <= '0;
            s1_valid  <= '0;
            s2_data   <= '0;
            s2_valid  <= '0;
            collision <= '0;
        end else begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                s1_data[p*WORD_BITS +: WORD_BITS] <= rd_word[p];
            end
            s1_valid  <= rd_req;
            s2_data   <= s1_data;
            s2_valid  <= s1_valid;
            collision <= wr_lose;
        end
    end

    assign bus.out_data      = (READ_LATENCY == 2) ? s2_data  : s1_data;
    assign bus.out_valid     = (READ_LATENCY == 2) ? s2_valid : s1_valid;
    assign bus.out_collision = collision;
    assign bus.out_busy      = busy;
endmodule

// File: tb/tb_ram_nport.sv
// Scoreboard bench for ram_nport: two instances share stimulus, one
// read-first with latency 1, one write-first with latency 2.
module tb_ram_nport;
    localparam int AB = 4;
    localparam int WB = 32;
    localparam int NW = 8;
    localparam int NP = 2;
    localparam int NB = 4;
    localparam logic [WB-1:0] INIT = 32'h0000_005A;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ram_nport_if #(.NUM_PORTS(NP), .ADDR_BITS(AB), .WORD_BITS(WB), .NUM_BYTES(NB)) bus0 ();
    ram_nport_if #(.NUM_PORTS(NP), .ADDR_BITS(AB), .WORD_BITS(WB), .NUM_BYTES(NB)) bus1 ();

    ram_nport #(
        .ADDR_BITS(AB), .WORD_BITS(WB), .NUM_WORDS(NW), .NUM_PORTS(NP),
        .BYTE_BITS(8), .READ_LATENCY(1), .WRITE_MODE(0), .ALL_WRITE(1),
        .CLEAR_ON_RESET(1), .INIT_VALUE(INIT)
    ) dut0 (.in_clk(clk), .in_rst(rst_n), .bus(bus0.slave));

    ram_nport #(
        .ADDR_BITS(AB), .WORD_BITS(WB), .NUM_WORDS(NW), .NUM_PORTS(NP),
        .BYTE_BITS(8), .READ_LATENCY(2), .WRITE_MODE(1), .ALL_WRITE(1),
        .CLEAR_ON_RESET(1), .INIT_VALUE(INIT)
    ) dut1 (.in_clk(clk), .in_rst(rst_n), .bus(bus1.slave));

    typedef struct { int due; logic [WB-1:0] data; } rd_exp_t;
    typedef struct { int due; logic [NP-1:0] vec; } col_exp_t;

    rd_exp_t  rdq  [2*NP][$];
    col_exp_t colq [2][$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int clear_left = 0;
    logic [WB-1:0] ref_mem [NW];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a cycle's requests are applied to an abstract memory.
    // Per address, the first port in index order that writes takes it.
    task automatic apply(input logic [1:0] re, input logic [1:0] we, input logic [7:0] be,
                         input logic [7:0] ad, input logic [63:0] d);
        logic [WB-1:0] nm [NW];
        bit            taken [NW];
        logic [NP-1:0] col;
        logic [WB-1:0] e0, e1;
        int            a;
        bus0.in_read_ena = re;  bus1.in_read_ena = re;
        bus0.in_write_ena = we; bus1.in_write_ena = we;
        bus0.in_byte_ena = be;  bus1.in_byte_ena = be;
        bus0.in_addr = ad;      bus1.in_addr = ad;
        bus0.in_data = d;       bus1.in_data = d;
        if (clear_left > 0) begin
            clear_left--;
            return;
        end
        nm = ref_mem;
        col = '0;
        for (int i = 0; i < NW; i++) taken[i] = 1'b0;
        for (int p = 0; p < NP; p++) begin
            a = int'(ad[p*AB +: AB]);
            if (we[p] && a < NW && be[p*NB +: NB] != 4'b0) begin
                if (taken[a]) col[p] = 1'b1;
                else begin
                    taken[a] = 1'b1;
                    for (int b = 0; b < NB; b++)
                        if (be[p*NB + b]) nm[a][b*8 +: 8] = d[p*WB + b*8 +: 8];
                end
            end
        end
        for (int p = 0; p < NP; p++) begin
            if (re[p]) begin
                a = int'(ad[p*AB +: AB]);
                e0 = '0;
                e1 = '0;
                if (a < NW) begin
                    e0 = ref_mem[a];
                    e1 = nm[a];
                end
                rdq[p].push_back('{cyc + 1, e0});
                rdq[NP + p].push_back('{cyc + 2, e1});
            end
        end
        ref_mem = nm;
        if (col != '0) begin
            colq[0].push_back('{cyc + 1, col});
            colq[1].push_back('{cyc + 1, col});
        end
    endtask

    task automatic cycle(input logic [1:0] re, input logic [1:0] we, input logic [7:0] be,
                         input logic [7:0] ad, input logic [63:0] d);
        @(posedge clk);
        #1;
        apply(re, we, be, ad, d);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(2'b00, 2'b00, 8'h00, 8'h00, 64'h0);
    endtask

    task automatic rnd_cycle();
        logic [7:0] ad;
        ad = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
        cycle(2'($urandom), 2'($urandom), 8'($urandom), ad, {$urandom, $urandom});
    endtask

    task automatic assert_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        clear_left = 0;
        for (int k = 0; k < 2*NP; k++) rdq[k].delete();
        colq[0].delete();
        colq[1].delete();
        apply(2'b00, 2'b00, 8'h00, 8'h00, 64'h0);
        repeat (2) @(negedge clk);
        chk(bus0.out_busy === 1'b1 && bus1.out_busy === 1'b1, "busy in reset",
            {62'b0, bus1.out_busy, bus0.out_busy}, 64'h3);
    endtask

    // Release reset and count cycles with busy high; requests made during
    // the clear must have no effect.
    task automatic release_and_count();
        int cnt0, cnt1;
        cnt0 = 0;
        cnt1 = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_left = NW;
        for (int i = 0; i < NW; i++) ref_mem[i] = INIT;
        apply(2'b00, 2'b00, 8'h00, 8'h00, 64'h0);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus0.out_busy === 1'b1) cnt0++;
            if (bus1.out_busy === 1'b1) cnt1++;
            if (k < 7) rnd_cycle();
            else idle(1);
        end
        chk(cnt0 == NW, "busy cycles dut0", 64'(cnt0), 64'(NW));
        chk(cnt1 == NW, "busy cycles dut1", 64'(cnt1), 64'(NW));
    endtask

    task automatic read_sweep();
        for (int a = 0; a < NW; a++)
            cycle(2'b11, 2'b00, 8'h00, {4'(NW - 1 - a), 4'(a)}, 64'h0);
    endtask

    // Monitor: pops expected responses when due, otherwise requires idle outputs.
    logic [NP-1:0]    m_v, m_c;
    logic [NP*WB-1:0] m_d;
    rd_exp_t          m_e;
    col_exp_t         m_ce;
    int               m_k;
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            m_v = (d == 0) ? bus0.out_valid : bus1.out_valid;
            m_d = (d == 0) ? bus0.out_data : bus1.out_data;
            m_c = (d == 0) ? bus0.out_collision : bus1.out_collision;
            for (int p = 0; p < NP; p++) begin
                m_k = d*NP + p;
                if (rdq[m_k].size() > 0 && rdq[m_k][0].due == cyc) begin
                    m_e = rdq[m_k].pop_front();
                    chk(m_v[p] === 1'b1 && m_d[p*WB +: WB] === m_e.data,
                        $sformatf("read dut%0d port%0d", d, p),
                        {31'b0, m_v[p], m_d[p*WB +: WB]}, {32'd1, m_e.data});
                end else begin
                    chk(m_v[p] === 1'b0 && m_d[p*WB +: WB] === '0,
                        $sformatf("idle dut%0d port%0d", d, p),
                        {31'b0, m_v[p], m_d[p*WB +: WB]}, 64'h0);
                end
            end
            if (colq[d].size() > 0 && colq[d][0].due == cyc) begin
                m_ce = colq[d].pop_front();
                chk(m_c === m_ce.vec, $sformatf("collision dut%0d", d), 64'(m_c), 64'(m_ce.vec));
            end else begin
                chk(m_c === '0, $sformatf("no collision dut%0d", d), 64'(m_c), 64'h0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bus0.in_read_ena = '0; bus0.in_write_ena = '0; bus0.in_byte_ena = '0;
        bus0.in_addr = '0;     bus0.in_data = '0;
        bus1.in_read_ena = '0; bus1.in_write_ena = '0; bus1.in_byte_ena = '0;
        bus1.in_addr = '0;     bus1.in_data = '0;

        assert_reset();
        release_and_count();
        read_sweep();
        idle(3);

        // byte-lane merge
        cycle(2'b00, 2'b01, 8'h0F, 8'h02, {32'h0, 32'hAABB_CCDD});
        cycle(2'b00, 2'b01, 8'h05, 8'h02, {32'h0, 32'h1122_3344});
        cycle(2'b01, 2'b00, 8'h00, 8'h02, 64'h0);
        // same-address write collision
        cycle(2'b00, 2'b11, 8'hFF, 8'h55, {32'h22, 32'h11});
        cycle(2'b01, 2'b00, 8'h00, 8'h05, 64'h0);
        // zero byte enable does not collide
        cycle(2'b00, 2'b11, 8'h0F, 8'h66, {32'h77, 32'h66});
        cycle(2'b10, 2'b00, 8'h00, 8'h60, 64'h0);
        // read-during-write across ports, both directions
        cycle(2'b00, 2'b01, 8'h0F, 8'h03, {32'h0, 32'h07});
        cycle(2'b10, 2'b01, 8'h0F, 8'h33, {32'h0, 32'h99});
        cycle(2'b01, 2'b10, 8'hF0, 8'h44, {32'h1234_5678, 32'h0});
        // back-to-back reads and an out-of-range read
        cycle(2'b01, 2'b00, 8'h00, 8'h00, 64'h0);
        cycle(2'b01, 2'b00, 8'h00, 8'h01, 64'h0);
        cycle(2'b01, 2'b00, 8'h00, 8'h02, 64'h0);
        cycle(2'b11, 2'b00, 8'h00, 8'h89, 64'h0);
        // out-of-range write is dropped
        cycle(2'b00, 2'b01, 8'h0F, 8'h09, {32'h0, 32'hDEAD_BEEF});
        cycle(2'b11, 2'b00, 8'h00, 8'h01, 64'h0);

        repeat (400) rnd_cycle();
        idle(3);

        // overwrite everything, then reset partway through the clear
        for (int a = 0; a < NW; a++)
            cycle(2'b00, 2'b01, 8'h0F, {4'h0, 4'(a)}, {32'h0, 32'hC0DE_0000 | 32'(a)});
        idle(4);
        assert_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_left = NW;
        apply(2'b00, 2'b00, 8'h00, 8'h00, 64'h0);
        idle(3);
        assert_reset();
        release_and_count();
        read_sweep();
        idle(4);

        for (int k = 0; k < 2*NP; k++)
            chk(rdq[k].size() == 0, $sformatf("read queue %0d drained", k), 64'(rdq[k].size()), 64'h0);
        chk(colq[0].size() == 0 && colq[1].size() == 0, "collision queues drained",
            64'(colq[0].size() + colq[1].size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
